// File: rtl/ethernet_st_error_sink_if.sv
// ---------------------------------------------------------------------------
// ethernet_st_error_sink_if
//
// Avalon-ST link bundle for the Ethernet error sink: the errored input stream
// (in_*) and the clean output stream (out_*), with no error field on out_*.
//
//   in_valid / in_ready           sink handshake (in_ready driven by the sink)
//   in_data, in_startofpacket,
//   in_endofpacket, in_empty,
//   in_error                      sink beat fields
//   out_valid / out_ready         source handshake (out_ready from downstream)
//   out_data, out_startofpacket,
//   out_endofpacket, out_empty    source beat fields
//
// Modports:
//   slave  - the error sink itself
//   master - whatever drives in_* and consumes out_* (upstream/downstream)
// ---------------------------------------------------------------------------
interface ethernet_st_error_sink_if #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2
);
    logic               in_ready;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               in_startofpacket;
    logic               in_endofpacket;
    logic [EMPTY_W-1:0] in_empty;
    logic               in_error;

    logic               out_ready;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_startofpacket;
    logic               out_endofpacket;
    logic [EMPTY_W-1:0] out_empty;

    modport slave (
        output in_ready,
        input  in_valid, in_data, in_startofpacket, in_endofpacket, in_empty, in_error,
        input  out_ready,
        output out_valid, out_data, out_startofpacket, out_endofpacket, out_empty
    );

    modport master (
        input  in_ready,
        output in_valid, in_data, in_startofpacket, in_endofpacket, in_empty, in_error,
        output out_ready,
        input  out_valid, out_data, out_startofpacket, out_endofpacket, out_empty
    );
endinterface

// File: rtl/ethernet_st_error_sink.sv
// ---------------------------------------------------------------------------
// ethernet_st_error_sink
//
// Consumes the per-beat error field of an Avalon-ST packet stream. A packet
// that raises error is cut short at the errored beat (forwarded with EOP=1,
// empty=0); its remaining beats are drained without reaching the output.
// Malformed framing (continuation beat between packets, SOP inside a packet)
// is repaired and counted.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   st           stream bundle (slave modport): in_* sink, out_* source.
//                in_ready is combinational, all out_* are registered.
//   cnt_clear    synchronous clear of both counters (wins over increment)
//   err_pkt_cnt  saturating count of truncated (errored) packets
//   stray_cnt    saturating count of malformed beats
//   err_pulse    registered one-cycle pulse, high in the cycle the errored
//                beat appears in the output register
// ---------------------------------------------------------------------------
module ethernet_st_error_sink #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    ethernet_st_error_sink_if.slave  st,
    input  logic                     cnt_clear,
    output logic [CNT_W-1:0]         err_pkt_cnt,
    output logic [CNT_W-1:0]         stray_cnt,
    output logic                     err_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // between packets
        ST_PKT  = 2'd1,   // inside a forwarded packet
        ST_DROP = 2'd2    // draining the tail of an errored packet
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_sop;
    logic               r_out_eop;
    logic [EMPTY_W-1:0] r_out_empty;
    logic [CNT_W-1:0]   r_err_pkt_cnt;
    logic [CNT_W-1:0]   r_stray_cnt;
    logic               r_err_pulse;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_load;
    logic               w_load_sop;
    logic               w_load_eop;
    logic [EMPTY_W-1:0] w_load_empty;
    logic               w_err_inc;
    logic               w_stray_inc;

    // DROP never waits on the output register: drained beats are not loaded.
    assign w_in_ready = (r_state == ST_DROP) | ~r_out_valid | st.out_ready;
    assign w_accept   = st.in_valid & w_in_ready;

    // -----------------------------------------------------------------------
    // Next-state and beat-steering logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_sop   = 1'b0;
        w_load_eop   = st.in_endofpacket;
        w_load_empty = st.in_empty;
        w_err_inc    = 1'b0;
        w_stray_inc  = 1'b0;

        unique case (r_state)
            ST_IDLE, ST_PKT: begin
                if (w_accept) begin
                    if (r_state == ST_IDLE && !st.in_startofpacket) begin
                        // Continuation beat with no packet open: discard.
                        w_stray_inc = 1'b1;
                    end else begin
                        w_load     = 1'b1;
                        // An SOP inside a packet is demoted to a continuation.
                        w_load_sop = (r_state == ST_IDLE);
                        if (r_state == ST_PKT && st.in_startofpacket) begin
                            w_stray_inc = 1'b1;
                        end
                        if (st.in_error) begin
                            // Truncate here; drain the tail unless this beat
                            // already closes the input packet.
                            w_load_eop   = 1'b1;
                            w_load_empty = '0;
                            w_err_inc    = 1'b1;
                            w_next_state = st.in_endofpacket ? ST_IDLE : ST_DROP;
                        end else begin
                            w_next_state = st.in_endofpacket ? ST_IDLE : ST_PKT;
                        end
                    end
                end
            end

            ST_DROP: begin
                if (w_accept && st.in_endofpacket) begin
                    w_next_state = ST_IDLE;
                end
            end

            default: w_next_state = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Output register: loads on a forwarded beat, otherwise holds its fields
    // and only drops valid once downstream has taken the beat.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the data path is reset too, since downstream observes
            // out_data as zero out of reset rather than as don't-care.
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_empty <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= st.in_data;
            r_out_sop   <= w_load_sop;
            r_out_eop   <= w_load_eop;
            r_out_empty <= w_load_empty;
        end else if (st.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Statistics: saturating counters, clear has priority over increment
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_pkt_cnt <= '0;
            r_stray_cnt   <= '0;
            r_err_pulse   <= 1'b0;
        end else begin
            r_err_pulse <= w_err_inc;

            if (cnt_clear) begin
                r_err_pkt_cnt <= '0;
            end else if (w_err_inc && (r_err_pkt_cnt != {CNT_W{1'b1}})) begin
                r_err_pkt_cnt <= r_err_pkt_cnt + CNT_W'(1);
            end

            if (cnt_clear) begin
                r_stray_cnt <= '0;
            end else if (w_stray_inc && (r_stray_cnt != {CNT_W{1'b1}})) begin
                r_stray_cnt <= r_stray_cnt + CNT_W'(1);
            end
        end
    end

    assign st.in_ready          = w_in_ready;
    assign st.out_valid         = r_out_valid;
    assign st.out_data          = r_out_data;
    assign st.out_startofpacket = r_out_sop;
    assign st.out_endofpacket   = r_out_eop;
    assign st.out_empty         = r_out_empty;
    assign err_pkt_cnt          = r_err_pkt_cnt;
    assign stray_cnt            = r_stray_cnt;
    assign err_pulse            = r_err_pulse;

endmodule

// File: doc/ethernet_st_error_sink.md
# ethernet_st_error_sink

Avalon-ST error consumer for the Ethernet datapath: accepts a 32-bit packet stream carrying a 1-bit error field and emits a clean stream with no error field. A packet that raises error is truncated at the errored beat, which leaves with forced end-of-packet. The remaining input beats of that packet are silently drained. It sits downstream of the error-adapter stage, ahead of the packet consumers, and keeps saturating counters of errored and malformed traffic.

## Interface
- DATA_W, 32, data bus width
- EMPTY_W, 2, empty field width (log2 of DATA_W/8)
- CNT_W, 16, width of the statistics counters
- clk  in  1  single clock; all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- in_ready  out  1  sink ready (combinational)
- in_valid  in  1  sink beat valid
- in_data  in  DATA_W  sink data
- in_startofpacket  in  1  sink SOP
- in_endofpacket  in  1  sink EOP
- in_empty  in  EMPTY_W  sink empty bytes (meaningful on EOP)
- in_error  in  1  sink error, per beat
- out_ready  in  1  source ready
- out_valid  out  1  source beat valid (registered)
- out_data  out  DATA_W  source data (registered)
- out_startofpacket  out  1  source SOP (registered)
- out_endofpacket  out  1  source EOP (registered)
- out_empty  out  EMPTY_W  source empty (registered)
- cnt_clear  in  1  synchronous clear of both counters, one-cycle pulse
- err_pkt_cnt  out  CNT_W  errored packets truncated, saturating
- stray_cnt  out  CNT_W  malformed beats seen (non-SOP in IDLE, SOP in PKT), saturating
- err_pulse  out  1  one-cycle pulse when an errored beat is accepted

## Operation
- Accept = in_valid & in_ready. in_ready = (state==DROP) | ~out_valid | out_ready.
- Output stage is a single register. It loads on every accepted beat that is forwarded. out_valid clears when out_ready & out_valid and no new beat loads.
- States:
  - IDLE: between packets.
  - PKT: inside a forwarded packet.
  - DROP: draining the rest of an errored packet.
- IDLE handling:
  - Accepted beat without SOP: discarded, not loaded. stray_cnt+1. State stays IDLE.
  - Accepted SOP, no error: forwarded. Next state IDLE if EOP, else PKT.
- PKT handling:
  - Accepted beat, no error: forwarded. EOP -> IDLE.
  - Accepted beat with SOP: forwarded with out_startofpacket=0. stray_cnt+1. Treated as a continuation beat.
- Error beat, in IDLE (with SOP) or PKT:
  - Beat is forwarded with out_endofpacket=1 and out_empty=0, regardless of input EOP/empty.
  - err_pkt_cnt+1; err_pulse=1 for that cycle.
  - Next state IDLE if in_endofpacket, else DROP.
- DROP handling:
  - in_ready=1 unconditionally; every accepted beat is discarded.
  - in_error is ignored, with no count and no pulse.
  - Accepted EOP -> IDLE.
  - An SOP arriving in DROP is also discarded.
- Counters:
  - Saturate at all-ones.
  - cnt_clear has priority over an increment in the same cycle; the counter reads 0 next cycle.
- Data and empty pass unmodified except the forced fields above.

## Timing
- Latency: 1 cycle from acceptance to out_valid. Throughput: 1 beat/cycle with out_ready held high.
- Forwarded-beat fields (data, SOP, EOP, empty) are held stable while out_valid & ~out_ready.
- Reset (async assert, sync release): state IDLE, out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_empty=0, err_pkt_cnt=0, stray_cnt=0, err_pulse=0. in_ready is therefore 1 after reset.
- Reset mid-packet: any partially forwarded packet is abandoned, with no EOP generated. The next input beat is judged from IDLE.
- Simultaneous SOP+EOP+error in IDLE: forwarded as a single-beat packet (EOP=1, empty=0). Counted once. State stays IDLE.
- out_ready low in DROP does not stall the input. A held forced-EOP beat stays in the output register until accepted.

## Test plan
- Clean 4-beat packet (SOP on beat 0, EOP on beat 3, empty=2), out_ready=1 -> identical 4 beats out one cycle later; counters 0; err_pulse never high.
- 6-beat packet, error on beat 2 -> 3 beats out, third has EOP=1 and empty=0; beats 3-5 drained with in_ready=1; err_pkt_cnt=1; err_pulse high exactly once.
- out_ready toggled 1010... during a clean 8-beat packet -> no beat lost or duplicated; output fields stable while stalled.
- Non-SOP beat in IDLE, then SOP inside a packet -> first beat dropped; second forwarded with SOP=0; stray_cnt=2.
- err_pkt_cnt preloaded to 0xFFFF via 65535 single-beat errored packets, then one more -> stays 0xFFFF. cnt_clear together with an error beat -> 0 next cycle.
- reset_n asserted mid-packet while out_valid=1 -> outputs 0 immediately, asynchronously. After release, next SOP packet forwards normally.
